// File: rtl/rotator64_ctrl.sv
// Sequencer for the 64-point twiddle rotator between two FFT stages: drives ED/START so sample k
// meets W64^k, tracks samples through the rotator latency and hands them downstream with flush.
`timescale 1ns/1ps
module rotator64_ctrl #(
  parameter int N   = 64,
  parameter int LAT = 3,
  parameter int FW  = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic          flush_i,
  output logic          rot_ed_o,
  output logic          rot_start_o,
  output logic          out_valid_o,
  output logic          out_first_o,
  input  logic          out_ready_i,
  output logic          busy_o,
  output logic [FW-1:0] frames_o
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARM   = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [LAT-1:0] vpipe_q, vpipe_d;
  logic [LAT-1:0] fpipe_q, fpipe_d;
  logic [FW-1:0]  frames_q, frames_d;

  logic stall;
  logic in_ready;
  logic accept;
  logic ed;
  logic start;

  // A stalled output freezes the whole rotator, including the input side.
  assign stall    = vpipe_q[LAT-1] && !out_ready_i;
  assign in_ready = (state_q == RUN) && !stall;
  assign accept   = in_ready && in_valid_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    frames_d = frames_q;
    ed       = 1'b0;
    start    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = ARM;
        end
      end
      ARM: begin
        ed    = !stall;
        start = !stall;
        if (!stall) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        ed = accept;
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          // Last sample restarts the twiddle address so the next frame needs no bubble.
          if (cnt_q == CNT_LAST) begin
            start    = 1'b1;
            frames_d = frames_q + 1'b1;
          end
        end else if (flush_i && !in_valid_i && (cnt_q == '0)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        ed = !stall && (|vpipe_q);
        if (vpipe_q == '0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    vpipe_d = vpipe_q;
    fpipe_d = fpipe_q;
    if (ed) begin
      vpipe_d = {vpipe_q[LAT-2:0], accept};
      fpipe_d = {fpipe_q[LAT-2:0], accept && (cnt_q == '0)};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      vpipe_q  <= '0;
      fpipe_q  <= '0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vpipe_q  <= vpipe_d;
      fpipe_q  <= fpipe_d;
      frames_q <= frames_d;
    end
  end

  assign in_ready_o  = in_ready;
  assign rot_ed_o    = ed;
  assign rot_start_o = start;
  assign out_valid_o = vpipe_q[LAT-1];
  assign out_first_o = fpipe_q[LAT-1];
  assign busy_o      = (state_q != IDLE) || (|vpipe_q);
  assign frames_o    = frames_q;

endmodule

// File: tb/tb_rotator64_ctrl.sv
// Bench for rotator64_ctrl: a tagged rotator stand-in carries (sample id, twiddle index) and the
// reference says the j-th accepted sample since reset must leave with twiddle j mod 64, in order.
`timescale 1ns/1ps
module tb_rotator64_ctrl;
  localparam int N   = 64;
  localparam int LAT = 3;
  localparam int FW  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic flush = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, rot_ed, rot_start, out_valid, out_first, busy;
  logic [FW-1:0] frames;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rotator64_ctrl #(.N(N), .LAT(LAT), .FW(FW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .flush_i    (flush),
    .rot_ed_o   (rot_ed),
    .rot_start_o(rot_start),
    .out_valid_o(out_valid),
    .out_first_o(out_first),
    .out_ready_i(out_ready),
    .busy_o     (busy),
    .frames_o   (frames)
  );

  // Rotator stand-in: never reset, so its twiddle address starts at a junk value.
  int din;
  int r_id [LAT];
  int r_tw [LAT];
  int r_addr = 37;
  always @(posedge clk) begin
    if (rot_ed) begin
      r_id[0] <= din;
      r_tw[0] <= r_addr;
      for (int i = 1; i < LAT; i++) begin
        r_id[i] <= r_id[i-1];
        r_tw[i] <= r_tw[i-1];
      end
      r_addr <= rot_start ? 0 : (r_addr + 1) % N;
    end
  end

  typedef struct {
    int   id;
    int   tw;
    logic first;
  } obs_t;

  obs_t obs_q[$];
  int   start_at[$];
  int   cyc = 0;
  int   n_acc, n_ed, n_bub, first_acc, first_ov, exp_out;
  int   bad_got, bad_want;
  logic s_ed, s_start, s_ir, s_ov, s_busy, s_acc;
  int   s_tag;

  task automatic clear_book();
    n_acc = 0; n_ed = 0; n_bub = 0; first_acc = -1; first_ov = -1; exp_out = 0;
    start_at.delete();
    obs_q.delete();
  endtask

  // One clock: drive at +1 after the edge, sample on the falling edge.
  task automatic step(input logic v, input logic r, input logic f);
    obs_t o;
    in_valid = v; out_ready = r; flush = f; din = n_acc;
    @(negedge clk);
    s_ed = rot_ed; s_start = rot_start; s_ir = in_ready; s_ov = out_valid;
    s_busy = busy; s_tag = r_id[LAT-1];
    s_acc = v && in_ready;
    if (s_acc && first_acc < 0) first_acc = cyc;
    if (out_valid && first_ov < 0) first_ov = cyc;
    if (rot_ed) n_ed++;
    if (rot_ed && !s_acc) n_bub++;
    if (rot_start) start_at.push_back(n_acc + (s_acc ? 1 : 0));
    if (out_valid && r && rot_ed) begin
      o.id = r_id[LAT-1]; o.tw = r_tw[LAT-1]; o.first = out_first;
      obs_q.push_back(o);
    end
    @(posedge clk); #1;
    if (s_acc) n_acc++;
    cyc++;
  endtask

  task automatic apply_reset(input int hold);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (hold) @(posedge clk);
    #3 rst_n = 1'b1;
    clear_book();
    @(posedge clk); #1;
  endtask

  // Consumes observed outputs; returns how many differ from "id j carries twiddle j mod N".
  function automatic int drain_obs();
    int e;
    obs_t o;
    e = 0;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (o.id !== exp_out || o.tw !== exp_out % N || o.first !== (exp_out % N == 0)) begin
        if (e == 0) begin
          bad_got  = o.id * 1000 + o.tw;
          bad_want = exp_out * 1000 + exp_out % N;
        end
        e++;
      end
      exp_out++;
    end
    return e;
  endfunction

  task automatic test_reset();
    #2;
    total++;
    if ({in_ready, rot_ed, rot_start, out_valid, out_first, busy} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=000000",
               {in_ready, rot_ed, rot_start, out_valid, out_first, busy});
    end
    total++;
    if (frames !== 16'd0) begin bad++; $display("FAIL reset_frames got=%0d want=0", frames); end
    apply_reset(2);
    step(1'b0, 1'b1, 1'b0);
    total++;
    if (s_busy !== 1'b0 || s_ir !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset got busy=%b rdy=%b want 0 0", s_busy, s_ir);
    end
  endtask

  task automatic test_single_frame();
    int e;
    apply_reset(2);
    for (int c = 0; c < 300 && n_acc < N; c++) step(1'b1, 1'b1, 1'b0);
    total++;
    if (n_acc !== N) begin bad++; $display("FAIL single_accepts got=%0d want=%0d", n_acc, N); end
    total++;
    if (n_bub !== 1) begin bad++; $display("FAIL single_bubbles got=%0d want=1", n_bub); end
    total++;
    if (start_at.size() !== 2 || start_at[0] !== 0 || start_at[1] !== N) begin
      bad++; $display("FAIL single_start got=%0d starts want=2 at 0,%0d", start_at.size(), N);
    end
    total++;
    if (first_ov - first_acc !== LAT) begin
      bad++; $display("FAIL single_latency got=%0d want=%0d", first_ov - first_acc, LAT);
    end
    total++;
    if (obs_q.size() == 0 || obs_q[0].first !== 1'b1 || obs_q[0].id !== 0) begin
      bad++; $display("FAIL single_first got=%0d outputs want first=1 id=0", obs_q.size());
    end
    total++;
    if (frames !== 16'd1) begin bad++; $display("FAIL single_frames got=%0d want=1", frames); end
    e = drain_obs();
    total++;
    if (e !== 0) begin bad++; $display("FAIL single_stream got=%0d want=%0d", bad_got, bad_want); end
    total++;
    if (exp_out !== N - LAT) begin bad++; $display("FAIL single_count got=%0d want=%0d", exp_out, N - LAT); end
    repeat (4) step(1'b0, 1'b1, 1'b0);
    total++;
    if (obs_q.size() !== 0 || s_ov !== 1'b1) begin
      bad++; $display("FAIL tail_held got=%0d outs ov=%b want 0 outs ov=1", obs_q.size(), s_ov);
    end
  endtask

  task automatic test_back_to_back();
    int e, nf;
    apply_reset(2);
    for (int c = 0; c < 600 && n_acc < 3 * N; c++) step(1'b1, 1'b1, 1'b0);
    total++;
    if (n_bub !== 1) begin bad++; $display("FAIL b2b_bubbles got=%0d want=1", n_bub); end
    e = 0;
    for (int i = 0; i < start_at.size(); i++) if (start_at[i] !== i * N) e++;
    total++;
    if (start_at.size() !== 4 || e !== 0) begin
      bad++; $display("FAIL b2b_start got=%0d starts %0d off want=4 0 off", start_at.size(), e);
    end
    nf = 0;
    foreach (obs_q[i]) if (obs_q[i].first) nf++;
    total++;
    if (nf !== 3) begin bad++; $display("FAIL b2b_firsts got=%0d want=3", nf); end
    e = drain_obs();
    total++;
    if (e !== 0) begin bad++; $display("FAIL b2b_stream got=%0d want=%0d", bad_got, bad_want); end
    total++;
    if (frames !== 16'd3) begin bad++; $display("FAIL b2b_frames got=%0d want=3", frames); end
  endtask

  task automatic test_stall();
    int base, stall_id, e;
    base = n_acc;
    for (int c = 0; c < 100 && n_acc < base + 20; c++) step(1'b1, 1'b1, 1'b0);
    stall_id = n_acc - LAT;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 1'b0);
      total++;
      if (s_ed !== 1'b0 || s_ir !== 1'b0) begin
        bad++; $display("FAIL stall_freeze got ed=%b rdy=%b want 0 0 (cycle %0d)", s_ed, s_ir, k);
      end
      total++;
      if (s_ov !== 1'b1 || s_tag !== stall_id) begin
        bad++; $display("FAIL stall_hold got ov=%b id=%0d want 1 %0d", s_ov, s_tag, stall_id);
      end
    end
    for (int c = 0; c < 200 && n_acc < base + N; c++) step(1'b1, 1'b1, 1'b0);
    e = drain_obs();
    total++;
    if (e !== 0 || exp_out !== n_acc - LAT) begin
      bad++; $display("FAIL stall_stream got=%0d out want=%0d", exp_out, n_acc - LAT);
    end
    total++;
    if (frames !== 16'd4) begin bad++; $display("FAIL stall_frames got=%0d want=4", frames); end
  endtask

  task automatic test_flush();
    int base, bub0, ed0, e;
    base = n_acc; bub0 = n_bub;
    for (int c = 0; c < 100 && n_acc < base + 17; c++) step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    total++;
    if (s_ir !== 1'b1) begin bad++; $display("FAIL flush_ignored got rdy=%b want=1", s_ir); end
    for (int c = 0; c < 200 && n_acc < base + N; c++) step(1'b1, 1'b1, 1'b1);
    total++;
    if (n_bub !== bub0 || frames !== 16'd5) begin
      bad++; $display("FAIL flush_frame got bub=%0d fr=%0d want %0d 5", n_bub - bub0, frames, 0);
    end
    step(1'b0, 1'b1, 1'b1);
    e = drain_obs();
    ed0 = n_ed;
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 1'b1, 1'b0);
      if (!s_busy) break;
    end
    total++;
    if (s_busy !== 1'b0) begin bad++; $display("FAIL drain_idle got busy=%b want=0", s_busy); end
    total++;
    if (n_ed - ed0 !== LAT) begin bad++; $display("FAIL drain_ed got=%0d want=%0d", n_ed - ed0, LAT); end
    total++;
    if (obs_q.size() !== LAT) begin bad++; $display("FAIL drain_outs got=%0d want=%0d", obs_q.size(), LAT); end
    e = e + drain_obs();
    total++;
    if (e !== 0 || exp_out !== n_acc) begin
      bad++; $display("FAIL drain_stream got=%0d out want=%0d", exp_out, n_acc);
    end
    total++;
    if (s_ir !== 1'b0 || s_ov !== 1'b0) begin
      bad++; $display("FAIL drain_quiet got rdy=%b ov=%b want 0 0", s_ir, s_ov);
    end
  endtask

  task automatic test_reset_midframe();
    int base, e;
    base = n_acc;
    for (int c = 0; c < 100 && n_acc < base + 30; c++) step(1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, rot_ed, rot_start, out_valid, out_first, busy} !== 6'b0 || frames !== 16'd0) begin
      bad++;
      $display("FAIL midreset_outputs got=%b fr=%0d want=000000 0",
               {in_ready, rot_ed, rot_start, out_valid, out_first, busy}, frames);
    end
    apply_reset(2);
    for (int c = 0; c < 200 && n_acc < N; c++) step(1'b1, 1'b1, 1'b0);
    total++;
    if (n_bub !== 1 || start_at.size() == 0 || start_at[0] !== 0) begin
      bad++; $display("FAIL midreset_arm got bub=%0d want=1 with start at 0", n_bub);
    end
    total++;
    if (obs_q.size() == 0 || obs_q[0].tw !== 0 || obs_q[0].id !== 0 || obs_q[0].first !== 1'b1) begin
      bad++; $display("FAIL midreset_w0 got=%0d outputs want sample 0 on twiddle 0", obs_q.size());
    end
    e = drain_obs();
    total++;
    if (e !== 0) begin bad++; $display("FAIL midreset_stream got=%0d want=%0d", bad_got, bad_want); end
    total++;
    if (frames !== 16'd1) begin bad++; $display("FAIL midreset_frames got=%0d want=1", frames); end
  endtask

  task automatic test_random();
    logic v, r, f, pend;
    int e;
    apply_reset(2);
    pend = 1'b0;
    for (int c = 0; c < 20000 && n_acc < 10 * N; c++) begin
      v = pend || ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 7) == 0);
      step(v, r, f);
      pend = v && !s_acc;
    end
    for (int c = 0; c < 50; c++) begin
      step(1'b0, 1'b1, 1'b1);
      if (!s_busy) break;
    end
    total++;
    if (n_acc !== 10 * N || s_busy !== 1'b0) begin
      bad++; $display("FAIL rand_done got acc=%0d busy=%b want %0d 0", n_acc, s_busy, 10 * N);
    end
    total++;
    if (frames !== 16'd10) begin bad++; $display("FAIL rand_frames got=%0d want=10", frames); end
    e = drain_obs();
    total++;
    if (e !== 0 || exp_out !== 10 * N) begin
      bad++; $display("FAIL rand_stream got=%0d bad of %0d want 0 of %0d", e, exp_out, 10 * N);
    end
    e = 0;
    foreach (start_at[i]) if (start_at[i] % N != 0) e++;
    total++;
    if (e !== 0 || start_at.size() < 11 || start_at[start_at.size()-1] !== 10 * N) begin
      bad++; $display("FAIL rand_start got=%0d misaligned of %0d want 0", e, start_at.size());
    end
  endtask

  initial begin
    clear_book();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
